// File: rtl/frog_game_pkg.sv
// rtl/frog_game_pkg.sv - game constants and state encoding shared by mover, referee and renderer
package frog_game_pkg;

  localparam int COORD_W      = 12;
  localparam int DEF_D_WIDTH  = 640;
  localparam int DEF_D_HEIGHT = 480;
  localparam int DEF_GOAL_Y   = 24;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_DYING     = 2'd1,
    ST_GAME_OVER = 2'd2,
    ST_UNUSED    = 2'd3
  } game_state_t;

  // A zero-width obstacle is a parked slot and never collides.
  function automatic logic box_enabled(input coord_t x1, input coord_t x2);
    return x1 != x2;
  endfunction

endpackage

// File: rtl/frog_referee_if.sv
// rtl/frog_referee_if.sv - frame inputs and referee outputs between mover, referee and renderer
interface frog_referee_if #(
  parameter int N_OBS = 4
);
  import frog_game_pkg::*;

  logic                     i_ani_stb;
  logic                     i_animate;
  coord_t                   i_frog_x1;
  coord_t                   i_frog_x2;
  coord_t                   i_frog_y1;
  coord_t                   i_frog_y2;
  logic [COORD_W*N_OBS-1:0] i_obs_x1;
  logic [COORD_W*N_OBS-1:0] i_obs_x2;
  logic [COORD_W*N_OBS-1:0] i_obs_y1;
  logic [COORD_W*N_OBS-1:0] i_obs_y2;
  logic                     o_respawn;
  logic                     o_hit;
  logic                     o_goal;
  logic [2:0]               o_lives;
  logic [7:0]               o_score;
  logic [1:0]               o_state;
  logic                     o_game_over;

  modport master (
    output i_ani_stb, i_animate,
    output i_frog_x1, i_frog_x2, i_frog_y1, i_frog_y2,
    output i_obs_x1, i_obs_x2, i_obs_y1, i_obs_y2,
    input  o_respawn, o_hit, o_goal, o_lives, o_score, o_state, o_game_over
  );

  modport slave (
    input  i_ani_stb, i_animate,
    input  i_frog_x1, i_frog_x2, i_frog_y1, i_frog_y2,
    input  i_obs_x1, i_obs_x2, i_obs_y1, i_obs_y2,
    output o_respawn, o_hit, o_goal, o_lives, o_score, o_state, o_game_over
  );

endinterface

// File: rtl/frog_referee_box_overlap.sv
// rtl/frog_referee_box_overlap.sv - strict-inequality overlap of the frog box against one obstacle box
module box_overlap
  import frog_game_pkg::*;
(
  input  coord_t fx1,
  input  coord_t fx2,
  input  coord_t fy1,
  input  coord_t fy2,
  input  coord_t ox1,
  input  coord_t ox2,
  input  coord_t oy1,
  input  coord_t oy2,
  output logic   overlap
);

  // Strict compares so boxes that merely share an edge do not collide.
  always_comb begin
    overlap = box_enabled(ox1, ox2)
              && (fx1 < ox2) && (fx2 > ox1)
              && (fy1 < oy2) && (fy2 > oy1);
  end

endmodule

// File: rtl/frog_referee.sv
// rtl/frog_referee.sv - per-frame collision/goal referee with lives, score and play/dying/game-over sequencing
module frog_referee
  import frog_game_pkg::*;
#(
  parameter int N_OBS        = 4,
  parameter int START_LIVES  = 3,
  parameter int DEATH_FRAMES = 30,
  parameter int GOAL_Y       = DEF_GOAL_Y,
  parameter int D_WIDTH      = DEF_D_WIDTH,
  parameter int D_HEIGHT     = DEF_D_HEIGHT
) (
  input  logic           i_clk,
  input  logic           i_rst,
  frog_referee_if.slave  bus
);

  localparam coord_t     WIDTH_C    = coord_t'(D_WIDTH);
  localparam coord_t     HEIGHT_C   = coord_t'(D_HEIGHT);
  localparam coord_t     GOAL_C     = coord_t'(GOAL_Y);
  localparam logic [5:0] LAST_DYING = 6'(DEATH_FRAMES - 1);
  localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);

  game_state_t state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [7:0]  score_q, score_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        respawn_q, respawn_d;
  logic        hit_q, hit_d;
  logic        goal_q, goal_d;

  logic [N_OBS-1:0] ovl;
  logic             tick;
  logic             out_of_bounds;
  logic             hit_now;
  logic             goal_now;

  for (genvar k = 0; k < N_OBS; k++) begin : g_obs
    box_overlap u_box (
      .fx1     (bus.i_frog_x1),
      .fx2     (bus.i_frog_x2),
      .fy1     (bus.i_frog_y1),
      .fy2     (bus.i_frog_y2),
      .ox1     (bus.i_obs_x1[COORD_W*k +: COORD_W]),
      .ox2     (bus.i_obs_x2[COORD_W*k +: COORD_W]),
      .oy1     (bus.i_obs_y1[COORD_W*k +: COORD_W]),
      .oy2     (bus.i_obs_y2[COORD_W*k +: COORD_W]),
      .overlap (ovl[k])
    );
  end

  // A hop left of x=0 wraps x1 to a huge value, so the first term also covers the left edge.
  assign out_of_bounds = (bus.i_frog_x1 >= WIDTH_C)
                      || (bus.i_frog_x2 >  WIDTH_C)
                      || (bus.i_frog_y2 >  HEIGHT_C);

  assign tick     = bus.i_animate && bus.i_ani_stb;
  assign hit_now  = (|ovl) || out_of_bounds;
  // The frog still sits on the goal row until the mover sees respawn, so one goal scores once.
  assign goal_now = (bus.i_frog_y1 <= GOAL_C) && !respawn_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_PLAY;
      lives_q   <= LIVES_INIT;
      score_q   <= 8'd0;
      cnt_q     <= 6'd0;
      respawn_q <= 1'b0;
      hit_q     <= 1'b0;
      goal_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      cnt_q     <= cnt_d;
      respawn_q <= respawn_d;
      hit_q     <= hit_d;
      goal_q    <= goal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    score_d   = score_q;
    cnt_d     = cnt_q;
    respawn_d = respawn_q;
    hit_d     = 1'b0;
    goal_d    = 1'b0;

    // An open window closes on the first tick the mover sees it; a new start below overrides.
    if (tick && respawn_q) begin
      respawn_d = 1'b0;
    end

    case (state_q)
      ST_PLAY: begin
        if (tick) begin
          if (hit_now) begin
            hit_d     = 1'b1;
            respawn_d = 1'b1;
            cnt_d     = 6'd0;
            lives_d   = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
            state_d   = (lives_q <= 3'd1) ? ST_GAME_OVER : ST_DYING;
          end else if (goal_now) begin
            goal_d    = 1'b1;
            respawn_d = 1'b1;
            if (score_q != 8'hFF) begin
              score_d = score_q + 8'd1;
            end
          end
        end
      end
      ST_DYING: begin
        if (tick) begin
          if (cnt_q == LAST_DYING) begin
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_GAME_OVER: begin
      end
      default: begin
        state_d = ST_PLAY;
      end
    endcase
  end

  assign bus.o_respawn   = respawn_q;
  assign bus.o_hit       = hit_q;
  assign bus.o_goal      = goal_q;
  assign bus.o_lives     = lives_q;
  assign bus.o_score     = score_q;
  assign bus.o_state     = state_q;
  assign bus.o_game_over = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_frog_referee.sv
// tb/tb_frog_referee.sv - self-checking bench for frog_referee with a behavioural game model
module tb_frog_referee;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stb = 1'b0;
  logic animate = 1'b1;
  logic [11:0] fx1 = 12'd100, fx2 = 12'd122, fy1 = 12'd200, fy2 = 12'd222;
  logic [11:0] ox1 [4];
  logic [11:0] ox2 [4];
  logic [11:0] oy1 [4];
  logic [11:0] oy2 [4];

  int passed = 0;
  int total = 0;

  int m_state, m_lives, m_score, m_left;
  bit m_resp, m_hit, m_goal;

  int bx1 [5] = '{4093, 619, 618, 100, 100};
  int bx2 [5] = '{15,   641, 640, 122, 122};
  int by1 [5] = '{200,  200, 200, 459, 458};
  int by2 [5] = '{222,  222, 222, 481, 480};
  int bexp[5] = '{1,    1,   0,   1,   0};

  always #5 clk = ~clk;

  frog_referee_if #(.N_OBS(4)) bus ();

  assign bus.i_ani_stb = stb;
  assign bus.i_animate = animate;
  assign bus.i_frog_x1 = fx1;
  assign bus.i_frog_x2 = fx2;
  assign bus.i_frog_y1 = fy1;
  assign bus.i_frog_y2 = fy2;
  for (genvar k = 0; k < 4; k++) begin : g_pack
    assign bus.i_obs_x1[12*k +: 12] = ox1[k];
    assign bus.i_obs_x2[12*k +: 12] = ox2[k];
    assign bus.i_obs_y1[12*k +: 12] = oy1[k];
    assign bus.i_obs_y2[12*k +: 12] = oy2[k];
  end

  frog_referee #(.N_OBS(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Game rules from the frog's point of view: does this frame kill, does it score.
  function automatic bit model_hit_now();
    for (int k = 0; k < 4; k++) begin
      if (ox1[k] != ox2[k] && fx1 < ox2[k] && fx2 > ox1[k] && fy1 < oy2[k] && fy2 > oy1[k])
        return 1'b1;
    end
    return (int'(fx1) >= 640) || (int'(fx2) > 640) || (int'(fy2) > 480);
  endfunction

  task automatic model_edge();
    bit tick, h, g;
    tick = animate && stb;
    h = model_hit_now();
    g = (int'(fy1) <= 24) && !m_resp;
    if (rst) begin
      m_state = 0; m_lives = 3; m_score = 0; m_left = 0;
      m_resp = 0; m_hit = 0; m_goal = 0;
      return;
    end
    m_hit = 0;
    m_goal = 0;
    if (!tick) return;
    if (m_state == 0 && h) begin
      m_hit = 1;
      m_lives = m_lives - 1;
      m_state = (m_lives == 0) ? 2 : 1;
      m_left = 30;
      m_resp = 1;
    end else if (m_state == 0 && g) begin
      m_goal = 1;
      m_score = (m_score >= 255) ? 255 : m_score + 1;
      m_resp = 1;
    end else begin
      m_resp = 0;
      if (m_state == 1) begin
        m_left = m_left - 1;
        if (m_left == 0) m_state = 0;
      end
    end
  endtask

  task automatic clk_step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stb = 1'b0;
    clk_step();
    rst = 1'b0;
  endtask

  task automatic clear_obs();
    for (int k = 0; k < 4; k++) begin
      ox1[k] = 12'd0; ox2[k] = 12'd0; oy1[k] = 12'd0; oy2[k] = 12'd0;
    end
  endtask

  task automatic set_frog(input int x1, input int x2, input int y1, input int y2);
    fx1 = 12'(x1); fx2 = 12'(x2); fy1 = 12'(y1); fy2 = 12'(y2);
  endtask

  // One strobe followed by an idle cycle; r is what the mover would sample on that tick.
  task automatic do_tick(output bit h, output bit g, output bit r);
    r = bus.o_respawn;
    stb = 1'b1;
    clk_step();
    h = bus.o_hit;
    g = bus.o_goal;
    stb = 1'b0;
    clk_step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.o_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", bus.o_state); else passed++;
    total++; if (bus.o_lives !== 3'd3) $display("FAIL reset_lives: got %0d want 3", bus.o_lives); else passed++;
    total++; if (bus.o_score !== 8'd0) $display("FAIL reset_score: got %0d want 0", bus.o_score); else passed++;
    total++; if (bus.o_respawn !== 1'b0) $display("FAIL reset_respawn: got %0d want 0", bus.o_respawn); else passed++;
    total++; if (bus.o_hit !== 1'b0 || bus.o_goal !== 1'b0) $display("FAIL reset_pulses: hit %0d goal %0d want 0 0", bus.o_hit, bus.o_goal); else passed++;
    total++; if (bus.o_game_over !== 1'b0) $display("FAIL reset_game_over: got %0d want 0", bus.o_game_over); else passed++;
  endtask

  task automatic test_edge_touch();
    bit h, g, r;
    int hc, rc;
    do_reset();
    clear_obs();
    set_frog(309, 331, 458, 480);
    ox1[0] = 12'd331; ox2[0] = 12'd360; oy1[0] = 12'd458; oy2[0] = 12'd480;
    do_tick(h, g, r);
    total++; if (h !== 1'b0) $display("FAIL edge_touch_hit: got %0d want 0", h); else passed++;
    total++; if (bus.o_lives !== 3'd3) $display("FAIL edge_touch_lives: got %0d want 3", bus.o_lives); else passed++;
    ox1[0] = 12'd330;
    do_tick(h, g, r);
    total++; if (h !== 1'b1) $display("FAIL overlap_hit: got %0d want 1", h); else passed++;
    total++; if (bus.o_lives !== 3'd2) $display("FAIL overlap_lives: got %0d want 2", bus.o_lives); else passed++;
    total++; if (bus.o_state !== 2'd1) $display("FAIL overlap_state: got %0d want 1", bus.o_state); else passed++;
    total++; if (bus.o_respawn !== 1'b1) $display("FAIL overlap_respawn: got %0d want 1", bus.o_respawn); else passed++;
    hc = 0; rc = 0;
    for (int i = 1; i <= 30; i++) begin
      do_tick(h, g, r);
      hc += int'(h);
      rc += int'(r);
      if (i == 29) begin
        total++; if (bus.o_state !== 2'd1) $display("FAIL dying_tick29_state: got %0d want 1", bus.o_state); else passed++;
      end
    end
    total++; if (hc != 0) $display("FAIL dying_extra_hits: got %0d want 0", hc); else passed++;
    total++; if (rc != 1) $display("FAIL respawn_ticks: got %0d want 1", rc); else passed++;
    total++; if (bus.o_state !== 2'd0) $display("FAIL dying_tick30_state: got %0d want 0", bus.o_state); else passed++;
  endtask

  task automatic test_game_over();
    bit h, g, r;
    do_reset();
    clear_obs();
    set_frog(309, 331, 458, 480);
    ox1[0] = 12'd330; ox2[0] = 12'd360; oy1[0] = 12'd458; oy2[0] = 12'd480;
    for (int n = 0; n < 3; n++) begin
      do_tick(h, g, r);
      total++; if (h !== 1'b1) $display("FAIL go_hit%0d: got %0d want 1", n, h); else passed++;
      total++; if (int'(bus.o_lives) != 2 - n) $display("FAIL go_lives%0d: got %0d want %0d", n, bus.o_lives, 2 - n); else passed++;
      if (n < 2) repeat (30) do_tick(h, g, r);
    end
    total++; if (bus.o_state !== 2'd2) $display("FAIL go_state: got %0d want 2", bus.o_state); else passed++;
    total++; if (bus.o_game_over !== 1'b1) $display("FAIL go_flag: got %0d want 1", bus.o_game_over); else passed++;
    for (int i = 0; i < 3; i++) begin
      do_tick(h, g, r);
      total++; if (h !== 1'b0) $display("FAIL go_ignored_hit: got %0d want 0", h); else passed++;
    end
    total++; if (bus.o_lives !== 3'd0 || bus.o_state !== 2'd2) $display("FAIL go_hold: lives %0d state %0d want 0 2", bus.o_lives, bus.o_state); else passed++;
    rst = 1'b1;
    stb = 1'b1;
    clk_step();
    rst = 1'b0;
    stb = 1'b0;
    total++; if (bus.o_lives !== 3'd3 || bus.o_state !== 2'd0) $display("FAIL go_reset: lives %0d state %0d want 3 0", bus.o_lives, bus.o_state); else passed++;
    total++; if (bus.o_hit !== 1'b0 || bus.o_game_over !== 1'b0) $display("FAIL go_reset_prio: hit %0d go %0d want 0 0", bus.o_hit, bus.o_game_over); else passed++;
  endtask

  task automatic test_goal();
    bit h, g, r;
    do_reset();
    clear_obs();
    set_frog(100, 122, 24, 46);
    do_tick(h, g, r);
    total++; if (g !== 1'b1 || bus.o_score !== 8'd1) $display("FAIL goal_first: goal %0d score %0d want 1 1", g, bus.o_score); else passed++;
    do_tick(h, g, r);
    total++; if (r !== 1'b1 || g !== 1'b0 || bus.o_score !== 8'd1) $display("FAIL goal_window: resp %0d goal %0d score %0d want 1 0 1", r, g, bus.o_score); else passed++;
    do_tick(h, g, r);
    total++; if (r !== 1'b0 || g !== 1'b1 || bus.o_score !== 8'd2) $display("FAIL goal_second: resp %0d goal %0d score %0d want 0 1 2", r, g, bus.o_score); else passed++;
    set_frog(100, 122, 200, 222);
    do_tick(h, g, r);
    set_frog(100, 122, 24, 46);
    ox1[0] = 12'd110; ox2[0] = 12'd130; oy1[0] = 12'd30; oy2[0] = 12'd60;
    do_tick(h, g, r);
    total++; if (r !== 1'b0 || h !== 1'b1 || g !== 1'b0) $display("FAIL goal_and_hit: resp %0d hit %0d goal %0d want 0 1 0", r, h, g); else passed++;
    total++; if (bus.o_score !== 8'd2 || bus.o_lives !== 3'd2) $display("FAIL goal_and_hit_counts: score %0d lives %0d want 2 2", bus.o_score, bus.o_lives); else passed++;
  endtask

  task automatic test_bounds();
    bit h, g, r;
    for (int i = 0; i < 5; i++) begin
      do_reset();
      clear_obs();
      set_frog(bx1[i], bx2[i], by1[i], by2[i]);
      do_tick(h, g, r);
      total++; if (int'(h) != bexp[i]) $display("FAIL bounds_%0d: hit %0d want %0d", i, h, bexp[i]); else passed++;
      total++; if (int'(bus.o_lives) != 3 - bexp[i]) $display("FAIL bounds_lives_%0d: got %0d want %0d", i, bus.o_lives, 3 - bexp[i]); else passed++;
    end
  endtask

  task automatic test_saturate();
    bit h, g, r;
    int gc;
    do_reset();
    clear_obs();
    set_frog(100, 122, 10, 32);
    gc = 0;
    for (int i = 0; i < 256; i++) begin
      do_tick(h, g, r);
      gc += int'(g);
      do_tick(h, g, r);
      gc += int'(g);
      if (i == 254) begin
        total++; if (bus.o_score !== 8'd255) $display("FAIL score_255: got %0d want 255", bus.o_score); else passed++;
      end
    end
    total++; if (bus.o_score !== 8'd255) $display("FAIL score_saturate: got %0d want 255", bus.o_score); else passed++;
    total++; if (gc != 256) $display("FAIL goal_pulses: got %0d want 256", gc); else passed++;
  endtask

  task automatic test_animate();
    bit h, g, r;
    int hc;
    do_reset();
    clear_obs();
    set_frog(309, 331, 458, 480);
    ox1[0] = 12'd330; ox2[0] = 12'd360; oy1[0] = 12'd458; oy2[0] = 12'd480;
    animate = 1'b0;
    hc = 0;
    repeat (4) begin
      do_tick(h, g, r);
      hc += int'(h);
    end
    total++; if (hc != 0 || bus.o_lives !== 3'd3 || bus.o_state !== 2'd0) $display("FAIL animate_low: hits %0d lives %0d state %0d want 0 3 0", hc, bus.o_lives, bus.o_state); else passed++;
    animate = 1'b1;
    do_tick(h, g, r);
    total++; if (h !== 1'b1 || bus.o_lives !== 3'd2) $display("FAIL animate_resume: hit %0d lives %0d want 1 2", h, bus.o_lives); else passed++;
    animate = 1'b0;
    repeat (4) do_tick(h, g, r);
    total++; if (bus.o_respawn !== 1'b1 || bus.o_state !== 2'd1) $display("FAIL animate_window_held: resp %0d state %0d want 1 1", bus.o_respawn, bus.o_state); else passed++;
    animate = 1'b1;
  endtask

  task automatic test_random();
    int x, y;
    do_reset();
    clear_obs();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 9) == 0) x = 4090 + int'($urandom_range(0, 5));
        else x = int'($urandom_range(0, 630));
        if ($urandom_range(0, 4) == 0) y = int'($urandom_range(0, 40));
        else y = int'($urandom_range(0, 470));
        set_frog(x, x + 22, y, y + 22);
        for (int k = 0; k < 4; k++) begin
          ox1[k] = 12'($urandom_range(0, 620));
          ox2[k] = ox1[k] + 12'($urandom_range(0, 40));
          oy1[k] = 12'($urandom_range(0, 460));
          oy2[k] = oy1[k] + 12'd20;
        end
      end
      animate = ($urandom_range(0, 7) != 0);
      stb = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 199) == 0);
      clk_step();
      total++; if (int'(bus.o_state) != m_state) $display("FAIL rnd_state c%0d: got %0d want %0d", c, bus.o_state, m_state); else passed++;
      total++; if (int'(bus.o_lives) != m_lives) $display("FAIL rnd_lives c%0d: got %0d want %0d", c, bus.o_lives, m_lives); else passed++;
      total++; if (int'(bus.o_score) != m_score) $display("FAIL rnd_score c%0d: got %0d want %0d", c, bus.o_score, m_score); else passed++;
      total++; if (bus.o_respawn !== m_resp) $display("FAIL rnd_respawn c%0d: got %0d want %0d", c, bus.o_respawn, m_resp); else passed++;
      total++; if (bus.o_hit !== m_hit) $display("FAIL rnd_hit c%0d: got %0d want %0d", c, bus.o_hit, m_hit); else passed++;
      total++; if (bus.o_goal !== m_goal) $display("FAIL rnd_goal c%0d: got %0d want %0d", c, bus.o_goal, m_goal); else passed++;
      total++; if (bus.o_game_over !== (m_state == 2)) $display("FAIL rnd_game_over c%0d: got %0d want %0d", c, bus.o_game_over, m_state == 2); else passed++;
    end
    rst = 1'b0;
    stb = 1'b0;
    animate = 1'b1;
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_edge_touch();
    test_game_over();
    test_goal();
    test_bounds();
    test_saturate();
    test_animate();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
